hud_digit_writer: RTL
=====================

# hud_digit_writer

Per-blob hit counter and write-side driver for the HUD digit renderer. Counts drum hits per tracked blob as modulo-10 digits. Streams changed digits to the renderer's `write`/`num`/`blob` port, only during vertical blanking, so a digit never changes mid-frame. Sits between the blob/hit detection logic and `hud_digits`, sharing the XVGA `vcount`.

## Interface
Parameters:
- `VACTIVE`, 768: first `vcount` value that counts as vertical blanking.

Ports:
- `clk`, in, 1: system (pixel) clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `hit`, in, 1: one-cycle strobe; a hit occurred on `hit_blob`.
- `hit_blob`, in, 4: blob index, 0–15, of the hit.
- `clear`, in, 1: one-cycle strobe; zero all counters.
- `vcount`, in, 10: current XVGA line.
- `write`, out, 1: one-cycle write strobe to `hud_digits`.
- `num`, out, 4: digit value 0–9; valid when `write`=1.
- `blob`, out, 4: digit slot, 0–15; valid when `write`=1.
- `busy`, out, 1: OR of all dirty bits; the display is stale.

## Operation
State:
- 16 × 4-bit counters `cnt[i]`.
- 16 dirty bits `dirty[i]`.
- 4-bit scan pointer `ptr`.
- 1-bit state register, `ACTIVE` or `BLANK`.

Counting:
- On `hit`, `cnt[hit_blob]` becomes (`cnt` + 1) mod 10, so 9 goes to 0. `dirty[hit_blob]` is set to 1.
- On `clear`, all `cnt` become 0 and all `dirty` are set to 1, so zeros get repainted.
- `clear` and `hit` in the same cycle: `clear` wins and the hit is dropped.

State machine:
- In `ACTIVE`, if `vcount >= VACTIVE`, go to `BLANK` and set `ptr` to 0.
- In `BLANK`, if `vcount < VACTIVE`, go to `ACTIVE`.
- The transition takes effect on the next edge. The state therefore lags `vcount` by 1 cycle.

Scan, only while the state is `BLANK`:
- Each cycle, `ptr` increments and wraps from 15 to 0. The pointer only moves in `BLANK` and holds its value in `ACTIVE`.
- If `dirty[ptr]`=1 in a `BLANK` cycle, the next edge registers `write`=1, `num`=`cnt[ptr]` (value before any same-cycle hit), `blob`=`ptr`, and clears `dirty[ptr]`.
- Same-cycle `hit` on `ptr`: the increment applies and `dirty[ptr]` stays 1. The new value is emitted on the next pass.
- Same-cycle `clear`: `dirty[ptr]` stays 1. The emitted `num` is the pre-clear value, and a zero follows on a later pass.
- Otherwise `write`=0. `num` and `blob` hold their last value.

Reset:
- `cnt` all 0, `dirty` all 1 so the first blanking interval paints 16 zeros.
- `ptr`=0, state `ACTIVE`.
- Outputs: `write`=0, `num`=0, `blob`=0, `busy`=1 (combinational from `dirty`).
- Reset asserted mid-scan aborts the scan immediately. `write` is 0 on the next cycle.

## Timing
- Every output except `busy` is registered. `busy` is combinational from the dirty bits.
- `write` latency: 1 cycle after a `BLANK` cycle in which `dirty[ptr]`=1. Back-to-back writes occur when consecutive slots are dirty.
- A full sweep of 16 slots takes 16 `BLANK` cycles. Blanking at 1024×768 is 38 lines × 1344 cycles, so every dirty slot is emitted within the first blanking interval after it became dirty.
- Worst-case hit-to-display latency: one frame plus 17 cycles.
- There is no handshake back from `hud_digits`. Every write is assumed accepted in the cycle it is presented.
- `write` is never 1 in the cycle after `ACTIVE` was the registered state.

## Test plan
- **Reset paint:** assert `reset`, then sweep `vcount` to 768. Required: 16 writes, `blob`=0..15 in order with `num`=0, no writes before the state is `BLANK`, and `busy` falling to 0 after the last write.
- **Hit counting and wrap:** during `ACTIVE`, send 12 hits on blob 5 with no writes. At the next blanking interval, exactly one write occurs: `blob`=5, `num`=2.
- **Hit on the scanned slot:** in `BLANK`, hit blob 3 in the cycle `ptr`=3 while `dirty[3]`=1 and `cnt[3]`=4. Required: a write with `num`=4, then `num`=5 when `ptr` returns to 3, 16 cycles later.
- **Clear vs hit:** set `cnt[7]`=6, then pulse `clear` and `hit`(`hit_blob`=7) in the same cycle. Required: all 16 slots are written with `num`=0 in the next blanking interval.
- **Blank exit:** drop `vcount` below 768 while slots 8–15 are still dirty. Required: `write`=0 from the cycle after the state returns to `ACTIVE`, and the remaining slots are emitted starting from `ptr`=0 in the next blanking interval.
- **Mid-scan reset:** assert `reset` in `BLANK` after 5 writes. Required: `write`=0, `num`=0, `blob`=0 on the next cycle and `busy`=1.

Source files
------------

// File: rtl/hud_digit_writer.sv
// Per-blob modulo-10 hit counters that stream changed digits to hud_digits,
// writing only during vertical blanking so a digit never changes mid-frame.
module hud_digit_writer #(
    parameter int VACTIVE = 768
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit,
    input  logic [3:0] hit_blob,
    input  logic       clear,
    input  logic [9:0] vcount,
    output logic       write,
    output logic [3:0] num,
    output logic [3:0] blob,
    output logic       busy
);

    localparam logic [9:0] VBLANK_START = 10'(VACTIVE);

    typedef enum logic {
        ACTIVE,
        BLANK
    } state_t;

    state_t      state;
    logic [3:0]  cnt [16];
    logic [15:0] dirty;
    logic [3:0]  ptr;
    logic        in_blank;

    function automatic logic [3:0] digit_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    assign in_blank = (vcount >= VBLANK_START);
    assign busy     = |dirty;

    // Later assignments override earlier ones: the scan clears dirty[ptr]
    // first, then clear/hit can set it again in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACTIVE;
            ptr   <= 4'd0;
            write <= 1'b0;
            num   <= 4'd0;
            blob  <= 4'd0;
            dirty <= '1;
            for (int i = 0; i < 16; i++) cnt[i] <= 4'd0;
        end else begin
            write <= 1'b0;

            case (state)
                ACTIVE: begin
                    if (in_blank) begin
                        state <= BLANK;
                        ptr   <= 4'd0;
                    end
                end
                BLANK: begin
                    if (!in_blank) state <= ACTIVE;
                    ptr <= ptr + 4'd1;
                    if (dirty[ptr]) begin
                        write      <= 1'b1;
                        num        <= cnt[ptr];
                        blob       <= ptr;
                        dirty[ptr] <= 1'b0;
                    end
                end
                default: state <= ACTIVE;
            endcase

            if (clear) begin
                dirty <= '1;
                for (int i = 0; i < 16; i++) cnt[i] <= 4'd0;
            end else if (hit) begin
                cnt[hit_blob]   <= digit_inc(cnt[hit_blob]);
                dirty[hit_blob] <= 1'b1;
            end
        end
    end

endmodule
